sample_scheduler: RTL

- Walks the sample grid inside a triangle's bounding box and issues one sample location per cycle to the sample-test stage, together with the triangle and its colour.
- Sits between the bounding-box stage (R13) and the sample-test stage (R14 onward).
- Back-pressures the bounding-box stage with a halt signal while a triangle is being iterated.

---
 rtl/sample_scheduler_if.sv | 30 +++
 rtl/sample_scheduler.sv | 119 +++++++++++
 2 files changed

// File: rtl/sample_scheduler_if.sv
// R13 triangle/box handoff into the scheduler and the R14 sample stream out of it.
// master = surrounding pipeline (upstream driver + downstream consumer), slave = the scheduler.
interface sample_scheduler_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [SIGFIG-1:0] tri_R13S   [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R13U [COLORS];
  logic signed [SIGFIG-1:0] box_R13S   [2][2];
  logic                     validTri_R13H;
  logic        [3:0]        subSample_RnnnnU;

  logic                     halt_RnnnnnH;
  logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U  [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [2];
  logic                     validSamp_R14H;

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    input  halt_RnnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    output halt_RnnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sample_scheduler.sv
// Raster-walks a sample-aligned bounding box (1/4/16/64 spp), one sample per cycle, first sample 1 cycle after capture.
// Backpressure: halt is high for every TEST cycle; upstream is consumed only in WAIT, so a held triangle goes back-to-back.
module sample_scheduler #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic              clk,
  input  logic              rst,
  sample_scheduler_if.slave bus
);
  typedef enum logic {S_WAIT, S_TEST} state_t;
  state_t state, state_nxt;

  logic signed [SIGFIG-1:0] tri_q   [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_q [COLORS];
  logic signed [SIGFIG-1:0] samp_x, samp_y;
  logic signed [SIGFIG-1:0] ll_x, ur_x, ur_y;
  logic        [SIGFIG-1:0] step_q, step_dec;

  logic capture, adv_x, adv_row, box_ok;

  // One guard bit so x+step cannot wrap below ur when ur sits near the positive limit.
  logic signed [SIGFIG:0] x_inc, y_inc, ur_x_ext, ur_y_ext;
  assign x_inc    = $signed({samp_x[SIGFIG-1], samp_x}) + $signed({1'b0, step_q});
  assign y_inc    = $signed({samp_y[SIGFIG-1], samp_y}) + $signed({1'b0, step_q});
  assign ur_x_ext = $signed({ur_x[SIGFIG-1], ur_x});
  assign ur_y_ext = $signed({ur_y[SIGFIG-1], ur_y});

  assign box_ok = (bus.box_R13S[0][0] <= bus.box_R13S[1][0]) &&
                  (bus.box_R13S[0][1] <= bus.box_R13S[1][1]);

  always_comb begin
    step_dec = SIGFIG'(1) << RADIX;
    case (bus.subSample_RnnnnU)
      4'b1000: step_dec = SIGFIG'(1) << RADIX;
      4'b0100: step_dec = SIGFIG'(1) << (RADIX - 1);
      4'b0010: step_dec = SIGFIG'(1) << (RADIX - 2);
      4'b0001: step_dec = SIGFIG'(1) << (RADIX - 3);
      default: step_dec = SIGFIG'(1) << RADIX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    adv_x     = 1'b0;
    adv_row   = 1'b0;
    case (state)
      S_WAIT: begin
        // A degenerate box is consumed here without ever entering TEST.
        if (bus.validTri_R13H && box_ok) begin
          capture   = 1'b1;
          state_nxt = S_TEST;
        end
      end
      S_TEST: begin
        if (x_inc <= ur_x_ext) begin
          adv_x = 1'b1;
        end else if (y_inc <= ur_y_ext) begin
          adv_row = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      samp_x <= '0;
      samp_y <= '0;
      ll_x   <= '0;
      ur_x   <= '0;
      ur_y   <= '0;
      step_q <= '0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          tri_q[v][a] <= '0;
      for (int c = 0; c < COLORS; c++)
        color_q[c] <= '0;
    end else if (capture) begin
      samp_x <= bus.box_R13S[0][0];
      samp_y <= bus.box_R13S[0][1];
      ll_x   <= bus.box_R13S[0][0];
      ur_x   <= bus.box_R13S[1][0];
      ur_y   <= bus.box_R13S[1][1];
      step_q <= step_dec;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          tri_q[v][a] <= bus.tri_R13S[v][a];
      for (int c = 0; c < COLORS; c++)
        color_q[c] <= bus.color_R13U[c];
    end else if (adv_x) begin
      samp_x <= x_inc[SIGFIG-1:0];
    end else if (adv_row) begin
      samp_x <= ll_x;
      samp_y <= y_inc[SIGFIG-1:0];
    end
  end

  assign bus.halt_RnnnnnH   = (state == S_TEST);
  assign bus.validSamp_R14H = (state == S_TEST);
  assign bus.sample_R14S[0] = samp_x;
  assign bus.sample_R14S[1] = samp_y;
  assign bus.tri_R14S       = tri_q;
  assign bus.color_R14U     = color_q;
endmodule
